// File: rtl/uart_rx_if.sv
// Serial input and received-byte outputs of the 8N1 UART receiver.
// The receiver uses master; the side that drives the line and consumes bytes uses slave.
interface uart_rx_if;
    logic       uart_rx;
    logic [7:0] rx_data_o;
    logic       rx_valid_o;
    logic       rx_frame_err_o;
    logic       rx_busy_o;

    modport master (
        input  uart_rx,
        output rx_data_o, rx_valid_o, rx_frame_err_o, rx_busy_o
    );

    modport slave (
        output uart_rx,
        input  rx_data_o, rx_valid_o, rx_frame_err_o, rx_busy_o
    );
endinterface

// File: rtl/uart_rx.sv
// 8N1 UART receiver: 2-flop synchronizer, falling-edge start detection, mid-bit sampling.
// Delivers a one-cycle valid pulse per good byte, or a framing-error pulse when the stop bit is low.
module uart_rx #(
    parameter logic [31:0] MODULE_CLK_RATE   = 32'd100000000,
    parameter logic [31:0] UART_BAUDCLK_RATE = 32'd115200
) (
    input logic      clk,
    input logic      rst,
    uart_rx_if.master rx
);
    localparam logic [31:0] BAUD_DIV = MODULE_CLK_RATE / UART_BAUDCLK_RATE;
    localparam logic [31:0] HALF_DIV = BAUD_DIV / 32'd2;
    localparam logic [15:0] FULL_TC  = BAUD_DIV[15:0] - 16'd1;
    localparam logic [15:0] HALF_TC  = HALF_DIV[15:0] - 16'd1;

    typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_IDLE} state_t;

    state_t      state, state_nxt;
    logic        sync1, rx_s, rx_d;
    logic [1:0]  prime;
    logic [15:0] cnt;
    logic [2:0]  bit_idx;
    logic [7:0]  shreg;
    logic [7:0]  data_q;
    logic        valid_q, err_q;
    logic        fall, tc_half, tc_full, cnt_tc;
    logic        valid_nxt, err_nxt, busy;

    // The synchronizer resets high, so edge detection stays disabled until rx_d
    // holds a genuine pin sample; a line low through reset is then not a start.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1 <= 1'b1;
            rx_s  <= 1'b1;
            rx_d  <= 1'b1;
            prime <= 2'd0;
        end else begin
            sync1 <= rx.uart_rx;
            rx_s  <= sync1;
            rx_d  <= rx_s;
            if (prime != 2'd3) prime <= prime + 2'd1;
        end
    end

    assign fall    = (prime == 2'd3) && rx_d && !rx_s;
    assign tc_half = (cnt == HALF_TC);
    assign tc_full = (cnt == FULL_TC);
    assign cnt_tc  = (state == START) ? tc_half : tc_full;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:      if (fall) state_nxt = START;
            START:     if (tc_half) state_nxt = rx_s ? IDLE : DATA;
            DATA:      if (tc_full && (bit_idx == 3'd7)) state_nxt = STOP;
            STOP:      if (tc_full) state_nxt = rx_s ? IDLE : WAIT_IDLE;
            WAIT_IDLE: if (rx_s) state_nxt = IDLE;
            default:   state_nxt = IDLE;
        endcase
    end

    always_comb begin
        valid_nxt = 1'b0;
        err_nxt   = 1'b0;
        busy      = (state != IDLE);
        if (state == STOP && tc_full) begin
            valid_nxt = rx_s;
            err_nxt   = !rx_s;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt     <= '0;
            bit_idx <= '0;
            shreg   <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            valid_q <= valid_nxt;
            err_q   <= err_nxt;
            if (valid_nxt) data_q <= shreg;

            if (state == START || state == DATA || state == STOP)
                cnt <= cnt_tc ? '0 : cnt + 16'd1;
            else
                cnt <= '0;

            if (state == START && tc_half) bit_idx <= '0;
            if (state == DATA && tc_full) begin
                shreg   <= {rx_s, shreg[7:1]};
                bit_idx <= bit_idx + 3'd1;
            end
        end
    end

    assign rx.rx_data_o      = data_q;
    assign rx.rx_valid_o     = valid_q;
    assign rx.rx_frame_err_o = err_q;
    assign rx.rx_busy_o      = busy;
endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx: frames are driven onto the line and their expected
// outcome queued; a negedge monitor pops and compares on every valid/error pulse.
module tb_uart_rx;
    localparam int BAUD = 100;
    localparam int HALF = 50;

    typedef struct {
        logic       err;
        logic [7:0] data;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;
    exp_t sb[$];
    int   vtimes[$];
    int   last_pulse_cyc = 0;
    logic [7:0] last_good = 8'h00;
    logic watch_busy = 1'b0;
    int   busy_drops = 0;

    uart_rx_if bus();

    uart_rx #(
        .MODULE_CLK_RATE  (32'd10000000),
        .UART_BAUDCLK_RATE(32'd100000)
    ) dut (
        .clk(clk),
        .rst(rst),
        .rx (bus.master)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (watch_busy && !bus.rx_busy_o) busy_drops++;
            if (bus.rx_valid_o && bus.rx_frame_err_o) check("pulse_exclusive", 32'd1, 32'd0);
            if (bus.rx_valid_o || bus.rx_frame_err_o) begin
                last_pulse_cyc = cyc;
                if (bus.rx_valid_o) vtimes.push_back(cyc);
                if (sb.size() == 0) begin
                    check("unexpected_pulse", {bus.rx_valid_o, bus.rx_frame_err_o}, 32'd0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("pulse_kind", bus.rx_frame_err_o, e.err);
                    check("rx_data", bus.rx_data_o, e.data);
                end
            end
        end
    end

    task automatic hold_line(input logic v, input int n);
        bus.uart_rx = v;
        repeat (n) @(negedge clk);
    endtask

    // Caller must be at a negedge; frames follow each other with no gap.
    task automatic send_byte(input logic [7:0] b, input int bitp, input logic bad_stop);
        exp_t e;
        e.err  = bad_stop;
        e.data = bad_stop ? last_good : b;
        if (!bad_stop) last_good = b;
        sb.push_back(e);
        hold_line(1'b0, bitp);
        for (int i = 0; i < 8; i++) hold_line(b[i], bitp);
        hold_line(!bad_stop, bitp);
    endtask

    task automatic drain(input string tag);
        int n = 0;
        while (sb.size() != 0 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check(tag, sb.size(), 32'd0);
    endtask

    initial begin
        int t0;
        int nv;
        int diff;
        bus.uart_rx = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        check("reset_data", bus.rx_data_o, 32'h00);
        check("reset_valid", bus.rx_valid_o, 32'd0);
        check("reset_err", bus.rx_frame_err_o, 32'd0);
        check("reset_busy", bus.rx_busy_o, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        hold_line(1'b1, 20);

        // single frame, latency and busy coverage
        t0 = cyc;
        fork
            send_byte(8'h55, BAUD, 1'b0);
            begin
                repeat (5) @(negedge clk);
                watch_busy = 1'b1;
                repeat (940) @(negedge clk);
                watch_busy = 1'b0;
            end
        join
        drain("drain_55");
        diff = last_pulse_cyc - t0;
        check("latency_in_window", (diff >= 951 && diff <= 957), 32'd1);
        check("busy_whole_frame", busy_drops, 32'd0);
        check("err_stays_low", bus.rx_frame_err_o, 32'd0);

        // back-to-back frames with no idle gap
        hold_line(1'b1, 50);
        nv = vtimes.size();
        send_byte(8'hA3, BAUD, 1'b0);
        send_byte(8'h00, BAUD, 1'b0);
        send_byte(8'hFF, BAUD, 1'b0);
        drain("drain_b2b");
        check("b2b_count", vtimes.size() - nv, 32'd3);
        if (vtimes.size() - nv == 3) begin
            diff = vtimes[nv+1] - vtimes[nv];
            check("b2b_space1", (diff >= 10*BAUD-2 && diff <= 10*BAUD+2), 32'd1);
            diff = vtimes[nv+2] - vtimes[nv+1];
            check("b2b_space2", (diff >= 10*BAUD-2 && diff <= 10*BAUD+2), 32'd1);
        end

        // short low glitch must be ignored
        hold_line(1'b1, 50);
        hold_line(1'b0, HALF - 20);
        hold_line(1'b1, HALF + 30);
        check("glitch_idle", bus.rx_busy_o, 32'd0);
        send_byte(8'h3C, BAUD, 1'b0);
        drain("drain_3c");

        // bad stop bit followed by a break
        hold_line(1'b1, 50);
        send_byte(8'h81, BAUD, 1'b1);
        hold_line(1'b0, 3*BAUD);
        drain("drain_81_err");
        check("break_busy", bus.rx_busy_o, 32'd1);
        check("data_kept", bus.rx_data_o, 32'h3C);
        hold_line(1'b1, BAUD);
        check("break_released", bus.rx_busy_o, 32'd0);
        send_byte(8'h42, BAUD, 1'b0);
        drain("drain_42");

        // reset asserted during data bit 4 of 0xC7
        hold_line(1'b1, 50);
        hold_line(1'b0, BAUD);
        for (int i = 0; i < 4; i++) hold_line(((8'hC7 >> i) & 8'h01) != 8'h00, BAUD);
        hold_line(1'b0, HALF);
        check("midframe_busy", bus.rx_busy_o, 32'd1);
        #2 rst = 1'b1;
        #1;
        check("async_rst_data", bus.rx_data_o, 32'h00);
        check("async_rst_valid", bus.rx_valid_o, 32'd0);
        check("async_rst_err", bus.rx_frame_err_o, 32'd0);
        check("async_rst_busy", bus.rx_busy_o, 32'd0);
        last_good = 8'h00;
        bus.uart_rx = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        hold_line(1'b1, 2*BAUD);
        send_byte(8'h5A, BAUD, 1'b0);
        drain("drain_5a");

        // transmitter rate skew of +/-2%
        hold_line(1'b1, 50);
        send_byte(8'h96, 102, 1'b0);
        drain("drain_96_slow");
        hold_line(1'b1, 50);
        send_byte(8'h96, 98, 1'b0);
        drain("drain_96_fast");
        check("skew_data", bus.rx_data_o, 32'h96);

        // line held low through reset is not a start
        hold_line(1'b0, 10);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        hold_line(1'b0, 3*BAUD);
        check("low_through_reset", bus.rx_busy_o, 32'd0);
        hold_line(1'b1, 2*BAUD);
        send_byte(8'hE1, BAUD, 1'b0);
        drain("drain_e1");
        hold_line(1'b1, 50);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
